// File: rtl/rr_decode_arbiter_if.sv
// rtl/rr_decode_arbiter_if.sv - requester-side bus of the eight-way round-robin arbiter
interface rr_decode_arbiter_if;
  logic [7:0] i_req;
  logic       i_done;
  logic [7:0] o_gnt;
  logic [2:0] o_gnt_idx;
  logic       o_gnt_valid;
  logic       o_timeout;

  // Requester bank drives requests and release, observes grant
  modport master (
    output i_req,
    output i_done,
    input  o_gnt,
    input  o_gnt_idx,
    input  o_gnt_valid,
    input  o_timeout
  );

  // Arbiter consumes requests and release, drives grant
  modport slave (
    input  i_req,
    input  i_done,
    output o_gnt,
    output o_gnt_idx,
    output o_gnt_valid,
    output o_timeout
  );
endinterface

// File: rtl/rr_decode_arbiter.sv
// rtl/rr_decode_arbiter.sv - eight-way round-robin arbiter with one-hot grant decode and hold watchdog
module rr_decode_arbiter #(
  parameter int MAX_HOLD = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  rr_decode_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Last counter value at which an unreleased grant is forced off
  localparam logic [7:0] LP_HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam bit         LP_HOLD_EN   = (MAX_HOLD != 0);

  state_t     r_state;
  logic [2:0] r_last;
  logic [2:0] r_gnt_idx;
  logic       r_gnt_valid;
  logic [7:0] r_gnt;
  logic       r_timeout;
  logic [7:0] r_hold;

  logic [2:0] w_sel_idx;
  logic       w_sel_found;
  logic       w_rel_done;
  logic       w_rel_withdraw;
  logic       w_rel_hold;
  logic       w_release;

  // Rotating priority search starting just after the last owner, wrapping 7 -> 0
  always_comb begin
    w_sel_idx   = 3'd0;
    w_sel_found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (!w_sel_found && bus.i_req[r_last + 3'(k)]) begin
        w_sel_idx   = r_last + 3'(k);
        w_sel_found = 1'b1;
      end
    end
  end

  assign w_rel_done     = bus.i_done;
  assign w_rel_withdraw = !bus.i_req[r_gnt_idx];
  assign w_rel_hold     = LP_HOLD_EN && (r_hold == LP_HOLD_LAST);
  assign w_release      = w_rel_done || w_rel_withdraw || w_rel_hold;

  // Grant FSM; the one-hot grant is registered so reset clears it with no stale glitch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_last      <= 3'd7;
      r_gnt_idx   <= 3'd0;
      r_gnt_valid <= 1'b0;
      r_gnt       <= 8'h00;
      r_timeout   <= 1'b0;
      r_hold      <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_timeout <= 1'b0;
          if (w_sel_found) begin
            r_gnt_idx   <= w_sel_idx;
            r_last      <= w_sel_idx;
            r_gnt_valid <= 1'b1;
            r_gnt       <= 8'b1 << w_sel_idx;
            r_hold      <= 8'd0;
            r_state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_release) begin
            r_gnt_valid <= 1'b0;
            r_gnt       <= 8'h00;
            // Watchdog pulse only when nothing else explains the release
            r_timeout   <= w_rel_hold && !w_rel_done && !w_rel_withdraw;
            r_state     <= ST_GAP;
          end else begin
            r_hold <= r_hold + 8'd1;
          end
        end
        ST_GAP: begin
          r_timeout <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: begin
          r_gnt_valid <= 1'b0;
          r_gnt       <= 8'h00;
          r_timeout   <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_gnt       = r_gnt;
  assign bus.o_gnt_idx   = r_gnt_idx;
  assign bus.o_gnt_valid = r_gnt_valid;
  assign bus.o_timeout   = r_timeout;

endmodule

// File: doc/rr_decode_arbiter.md
# rr_decode_arbiter

Eight-way round-robin arbiter that shares one downstream resource between eight requesters and drives the resource's one-hot select lines through the 3-to-8 decode of the granted index. It sits between the requester bank and the shared datapath. It owns the grant state machine, the fairness pointer and a hold-timeout watchdog. Both encoded and decoded (one-hot) forms of the grant are registered outputs.

## Interface
- MAX_HOLD, 0: maximum grant duration in cycles, legal range 0..255; 0 disables the timeout.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low; deassertion is synchronised externally.
- REQ  in  8  level request per requester; bit i belongs to requester i.
- DONE  in  1  single-cycle release pulse from the current owner.
- GNT  out  8  one-hot grant: decode of GNT_IDX when GNT_VALID=1, else 8'h00.
- GNT_IDX  out  3  encoded index of the current or last owner.
- GNT_VALID  out  1  a grant is active.
- TIMEOUT  out  1  one-cycle pulse after a release forced by MAX_HOLD.

## Operation
- States:
  - IDLE: no grant.
  - BUSY: grant held.
  - GAP: one dead cycle between owners, with GNT=0.
- Reset values:
  - GNT=8'h00, GNT_IDX=3'd0, GNT_VALID=0, TIMEOUT=0.
  - State=IDLE, hold counter=0, last-owner pointer LAST=3'd7.
- IDLE, REQ!=0:
  - Select the first set bit searching LAST+1, LAST+2, … modulo 8. The search wraps from 7 to 0.
  - Register GNT_IDX=selected index, LAST=selected index, GNT_VALID=1.
  - Enter BUSY and clear the hold counter.
- IDLE, REQ==0: stay in IDLE. GNT_IDX and LAST hold their values.
- BUSY: release when any of the following is true at an edge:
  - DONE=1.
  - REQ[GNT_IDX]=0 (requester withdrew).
  - MAX_HOLD!=0 and hold counter == MAX_HOLD-1.
- BUSY, no release: increment the 8-bit hold counter.
- Release from BUSY:
  - Set GNT_VALID=0 and enter GAP.
  - Set TIMEOUT=1 only if the timeout term alone caused the release. If DONE or withdrawal coincides with the timeout, TIMEOUT stays 0.
- GAP: go unconditionally to IDLE next cycle. Clear TIMEOUT. REQ is ignored.
- DONE outside BUSY is ignored.
- Changes on REQ bits other than the owner's do not affect BUSY.
- GNT is a decoded copy of registered state. It must never show more than one bit set, including across reset.

## Timing
- Grant latency:
  - REQ seen at edge N while in IDLE → GNT/GNT_VALID high from edge N (visible in cycle N+1).
  - Combinational REQ→GNT paths are forbidden.
- Release latency: release condition sampled at edge M → GNT_VALID=0 after edge M.
- Back-to-back grants: after a release at edge M, GAP occupies cycle M+1, IDLE samples REQ at edge M+2, and the next grant is visible after edge M+2. Minimum owner-to-owner spacing is 2 cycles with GNT=0.
- Timeout: with MAX_HOLD=K>0, an unreleased grant is high for exactly K cycles. TIMEOUT is high for exactly 1 cycle, the GAP cycle.
- MAX_HOLD=1: the grant lasts exactly one cycle, then a forced release.
- Reset mid-BUSY: all outputs return to reset values asynchronously, with no one-cycle glitch of a stale GNT. After rst_n rises, the first grant search starts at index 0 (LAST=7).

## Test plan
- Fairness sweep:
  - Stimulus: hold REQ=8'hFF with MAX_HOLD=0, and pulse DONE one cycle after each grant appears.
  - Required response: GNT_IDX sequence 0,1,2,3,4,5,6,7,0. Each grant is separated by 2 GNT=0 cycles. GNT matches 1<<GNT_IDX every cycle.
- Wrap and skip:
  - Stimulus: after a grant to index 6 is released, drive REQ=8'b0000_0101.
  - Required response: next grant index 0, then index 2. Index 7 is skipped.
- Timeout:
  - Stimulus: MAX_HOLD=4, REQ=8'h10 held, DONE never asserted.
  - Required response: GNT=8'h10 for exactly 4 cycles. TIMEOUT is a single pulse in the following cycle. The grant is re-issued to index 4 two cycles after release.
- Simultaneous release:
  - Stimulus: MAX_HOLD=3, DONE on the third grant cycle.
  - Required response: release with TIMEOUT=0.
- Withdrawal:
  - Stimulus: requester 3 owns the grant, then drops REQ[3] while REQ[5]=1.
  - Required response: GNT drops the edge after the withdrawal. GNT=8'h20 follows 2 cycles later.
- Reset mid-grant:
  - Stimulus: assert rst_n=0 while GNT=8'h80, then release reset with REQ=8'hFF.
  - Required response: GNT=0 and GNT_VALID=0 immediately on reset assertion. The first grant after reset is index 0.
